dna_readout_ctrl: RTL and testbench
===================================

// Module: dna_readout_ctrl
// PURPOSE
//  Sequencer for the device DNA primitive (DNA_PORT / DNA_PORTE2). Drives READ/SHIFT/DIN, serially
//  captures the DNA word MSB-first, and presents it as a stable parallel value with a valid flag.
//  Sits between the primitive wrapper and the AXI4-Lite register file; the register file issues
//  start/clear and latches dna_value_o.
// PARAMETERS
//  DNA_BITS    57  number of DNA bits to shift (57 = 7Series DNA_PORT, 96 = DNA_PORTE2); legal 1..96
//  AUTO_START  1   1: one readout launched automatically on first clock after reset release
//  FAMILY_ID   7   constant reported on family_id_o (7 = 7Series, 2 = UltraScale)
// PORTS
//  s_axil_clk    in   1   clock; one clock; reset is asynchronous and active-low
//  s_axil_rstn   in   1   asynchronous active-low reset
//  start_i       in   1   request readout; accepted only in IDLE or DONE
//  clear_i       in   1   synchronous clear: abort, drop valid, return to IDLE
//  busy_o        out  1   high in LOAD and SHIFT
//  done_o        out  1   one-cycle pulse on entry to DONE
//  dna_valid_o   out  1   dna_value_o holds a complete readout
//  dna_value_o   out  96  captured DNA, right-aligned, upper 96-DNA_BITS bits zero
//  family_id_o   out  32  FAMILY_ID, zero-extended
//  dna_read_o    out  1   to primitive READ
//  dna_shift_o   out  1   to primitive SHIFT
//  dna_din_o     out  1   to primitive DIN, tied 0
//  dna_dout_i    in   1   from primitive DOUT
// BEHAVIOUR
//  Reset: state IDLE, cnt 0, shift reg 0, all 1-bit outputs 0, dna_value_o 0; AUTO_START arm flag set.
//  FSM IDLE -> LOAD -> SHIFT -> DONE; all primitive controls decoded from registered state only.
//   IDLE : if clear_i stay; else if start_i or arm flag -> LOAD (arm flag cleared).
//   LOAD : dna_read_o=1, dna_shift_o=0, one cycle; primitive loads at end of cycle -> SHIFT, cnt=0.
//   SHIFT: dna_read_o=0, dna_shift_o=1; each cycle shreg <= {shreg[94:0], dna_dout_i}, cnt++;
//          after sample with cnt==DNA_BITS-1 -> DONE. Exactly DNA_BITS samples, first sample = MSB.
//   DONE : dna_value_o <= shreg masked to DNA_BITS, dna_valid_o=1, done_o pulses on entry cycle;
//          stays until start_i (-> LOAD, dna_valid_o held 1 and old value kept until new DONE)
//          or clear_i (-> IDLE, valid 0, value 0).
//  Latency: start_i sampled high in cycle N -> LOAD in N+1 -> done_o and dna_valid_o in N+2+DNA_BITS.
//  start_i while busy: ignored, no queuing. clear_i wins over start_i in the same cycle; clear_i
//   mid-SHIFT aborts immediately, controls drop to 0 next cycle, partial data discarded.
//  cnt is 7 bits, never wraps (saturates by FSM exit). Async reset mid-readout: same as power-on
//   reset, including re-arming AUTO_START.
// CONFIGURATION
//  DNA_READOUT_MATCH_EN defined: adds input expected_dna_i[95:0] and output dna_match_o (1 bit);
//   dna_match_o registered on entry to DONE as (masked shreg == expected_dna_i), cleared with valid.
//  Not defined: neither port exists; no comparator logic.
// STRUCTURE
//  Package dna_readout_pkg: state enum {IDLE,LOAD,SHIFT,DONE}, DNA_BITS_7S=57, DNA_BITS_US=96,
//   FAMILY_ID_7S=7, FAMILY_ID_US=2, DNA_MAX_BITS=96.
//  One sub-module: dna_shift_capture (shift register + bit mask + optional comparator); FSM and
//   counter in top. Primitive instantiation stays outside this block.
// TESTING (bench models primitive as 96-bit shift reg loaded on READ, DOUT = current MSB)
//  AUTO_START=1, DNA_BITS=57, model 57'h010203040506070 -> done_o at cycle 59 after reset release,
//   dna_value_o=96'h0010203040506070, dna_valid_o=1.
//  DNA_BITS=96, AUTO_START=0, model 96'hA5A5_0000_1234_5678_9ABC_DEF0, start_i pulse at N ->
//   busy_o N+1..N+97, done_o at N+98, value matches exactly.
//  start_i pulsed mid-SHIFT -> no restart, single done_o, cycle count unchanged.
//  clear_i at SHIFT cnt=20 -> next cycle busy_o=0, dna_read_o=dna_shift_o=0, dna_valid_o=0, value 0.
//  Async reset asserted mid-SHIFT, released -> all outputs 0 during reset, fresh readout completes.
//  DNA_READOUT_MATCH_EN: expected = model -> dna_match_o=1; one bit flipped -> dna_match_o=0.

Source files
------------

// File: rtl/dna_readout_pkg.sv
// Shared state type and constants for the device DNA readout sequencer.
// Covers 7Series DNA_PORT (57 bits) and UltraScale DNA_PORTE2 (96 bits).
package dna_readout_pkg;

  localparam int unsigned DNA_MAX_BITS = 96;
  localparam int unsigned DNA_BITS_7S  = 57;
  localparam int unsigned DNA_BITS_US  = 96;
  localparam int unsigned FAMILY_ID_7S = 7;
  localparam int unsigned FAMILY_ID_US = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } dna_state_e;

  // Right-aligned mask with the low 'bits' bits set.
  function automatic logic [DNA_MAX_BITS-1:0] dna_mask(
    input int unsigned bits
  );
    logic [DNA_MAX_BITS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DNA_MAX_BITS; i++) begin
      if (i < bits) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dna_shift_capture.sv
// Serial DNA capture: MSB-first shift register, width mask, output latch.
// Optional comparator against an expected word under DNA_READOUT_MATCH_EN.
module dna_shift_capture
  import dna_readout_pkg::*;
#(
  parameter int unsigned DNA_BITS = DNA_BITS_7S
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic                    shift_i,
  input  logic                    capture_i,
  input  logic                    dout_i,
`ifdef DNA_READOUT_MATCH_EN
  input  logic [DNA_MAX_BITS-1:0] expected_i,
  output logic                    match_o,
`endif
  output logic [DNA_MAX_BITS-1:0] value_o
);

  localparam logic [DNA_MAX_BITS-1:0] MASK = dna_mask(DNA_BITS);

  logic [DNA_MAX_BITS-2:0] shreg_q;
  logic [DNA_MAX_BITS-1:0] shreg_d;
  logic [DNA_MAX_BITS-1:0] masked;

  // The final sample is folded in here so DONE sees the full word.
  assign shreg_d = {shreg_q, dout_i};
  assign masked  = shreg_d & MASK;

  // Shift register: emptied on abort or a new load, fills MSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else if (clr_i || load_i) begin
      shreg_q <= '0;
    end else if (shift_i) begin
      shreg_q <= shreg_d[DNA_MAX_BITS-2:0];
    end
  end

  // Output latch: holds the last complete word until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_o <= '0;
    end else if (clr_i) begin
      value_o <= '0;
    end else if (capture_i) begin
      value_o <= masked;
    end
  end

`ifdef DNA_READOUT_MATCH_EN
  // Compare result sampled together with the captured word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_o <= 1'b0;
    end else if (clr_i) begin
      match_o <= 1'b0;
    end else if (capture_i) begin
      match_o <= (masked == expected_i);
    end
  end
`endif

endmodule

// File: rtl/dna_readout_ctrl.sv
// Device DNA readout sequencer: drives READ/SHIFT, captures the word.
// Optional build macro: DNA_READOUT_MATCH_EN adds an expected-value match.
module dna_readout_ctrl
  import dna_readout_pkg::*;
#(
  parameter int unsigned DNA_BITS   = DNA_BITS_7S,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned FAMILY_ID  = FAMILY_ID_7S
) (
  input  logic                    s_axil_clk,
  input  logic                    s_axil_rstn,
  input  logic                    start_i,
  input  logic                    clear_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    dna_valid_o,
  output logic [DNA_MAX_BITS-1:0] dna_value_o,
  output logic [31:0]             family_id_o,
  output logic                    dna_read_o,
  output logic                    dna_shift_o,
  output logic                    dna_din_o,
`ifdef DNA_READOUT_MATCH_EN
  input  logic [DNA_MAX_BITS-1:0] expected_dna_i,
  output logic                    dna_match_o,
`endif
  input  logic                    dna_dout_i
);

  localparam logic [6:0] CNT_LAST = 7'(DNA_BITS - 1);

  dna_state_e state_q;
  logic [6:0] cnt_q;
  logic       arm_q;
  logic       done_q;
  logic       valid_q;
  logic       read_q;
  logic       shift_q;
  logic       capture;

  assign capture = (state_q == SHIFT) &&
                   (cnt_q == CNT_LAST) && !clear_i;

  assign busy_o      = read_q | shift_q;
  assign done_o      = done_q;
  assign dna_valid_o = valid_q;
  assign dna_read_o  = read_q;
  assign dna_shift_o = shift_q;
  assign dna_din_o   = 1'b0;
  assign family_id_o = 32'(FAMILY_ID);

  // Sequencer: state, bit counter, auto-start arm and control outputs.
  always_ff @(posedge s_axil_clk or negedge s_axil_rstn) begin
    if (!s_axil_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      arm_q   <= AUTO_START;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      read_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!clear_i && (start_i || arm_q)) begin
            state_q <= LOAD;
            arm_q   <= 1'b0;
            read_q  <= 1'b1;
          end
        end
        LOAD: begin
          read_q <= 1'b0;
          if (clear_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shift_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (clear_i) begin
            state_q <= IDLE;
            shift_q <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 7'd1;
            if (cnt_q == CNT_LAST) begin
              state_q <= DONE;
              shift_q <= 1'b0;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (clear_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else if (start_i) begin
            state_q <= LOAD;
            read_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          shift_q <= 1'b0;
        end
      endcase
    end
  end

  dna_shift_capture #(
    .DNA_BITS (DNA_BITS)
  ) u_capture (
    .clk        (s_axil_clk),
    .rst_n      (s_axil_rstn),
    .clr_i      (clear_i),
    .load_i     (state_q == LOAD),
    .shift_i    (state_q == SHIFT),
    .capture_i  (capture),
    .dout_i     (dna_dout_i),
`ifdef DNA_READOUT_MATCH_EN
    .expected_i (expected_dna_i),
    .match_o    (dna_match_o),
`endif
    .value_o    (dna_value_o)
  );

endmodule

// File: tb/tb_dna_readout_ctrl.sv
// Bench for dna_readout_ctrl: 57-bit auto-start and 96-bit manual copies.
// Primitive modelled as a shift register loaded on READ, DOUT = MSB.
module tb_dna_readout_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic st7 = 1'b0, cl7 = 1'b0;
  logic st96 = 1'b0, cl96 = 1'b0;
  logic busy7, done7, val7, rd7, sh7, din7, dout7;
  logic busy96, done96, val96, rd96, sh96, din96, dout96;
  logic [95:0] v7, v96;
  logic [31:0] fam7, fam96;
  logic [95:0] word7 = '0;
  logic [95:0] word96 = '0;
  logic [95:0] m7, m96;
`ifdef DNA_READOUT_MATCH_EN
  logic [95:0] exp7_i = '0;
  logic [95:0] exp96_i = '0;
  logic mt7, mt96;
`endif

  int nvec = 0;
  int nerr = 0;

  dna_readout_ctrl #(
    .DNA_BITS(57), .AUTO_START(1'b1), .FAMILY_ID(7)
  ) u7 (
    .s_axil_clk(clk), .s_axil_rstn(rstn),
    .start_i(st7), .clear_i(cl7),
    .busy_o(busy7), .done_o(done7),
    .dna_valid_o(val7), .dna_value_o(v7),
    .family_id_o(fam7),
    .dna_read_o(rd7), .dna_shift_o(sh7),
    .dna_din_o(din7),
`ifdef DNA_READOUT_MATCH_EN
    .expected_dna_i(exp7_i), .dna_match_o(mt7),
`endif
    .dna_dout_i(dout7)
  );

  dna_readout_ctrl #(
    .DNA_BITS(96), .AUTO_START(1'b0), .FAMILY_ID(2)
  ) u96 (
    .s_axil_clk(clk), .s_axil_rstn(rstn),
    .start_i(st96), .clear_i(cl96),
    .busy_o(busy96), .done_o(done96),
    .dna_valid_o(val96), .dna_value_o(v96),
    .family_id_o(fam96),
    .dna_read_o(rd96), .dna_shift_o(sh96),
    .dna_din_o(din96),
`ifdef DNA_READOUT_MATCH_EN
    .expected_dna_i(exp96_i), .dna_match_o(mt96),
`endif
    .dna_dout_i(dout96)
  );

  // Primitive models: 57-bit word left-aligned in a 96-bit register.
  always_ff @(posedge clk) begin
    if (rd7) m7 <= word7 << 39;
    else if (sh7) m7 <= m7 << 1;
    if (rd96) m96 <= word96;
    else if (sh96) m96 <= m96 << 1;
  end
  assign dout7  = m7[95];
  assign dout96 = m96[95];

  typedef struct {
    logic [95:0] word;
    logic [95:0] exp57;
    logic [95:0] exp96;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm,
                       input logic [95:0] act,
                       input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] ref_value(
    input logic [95:0] w, input int bits);
    logic [95:0] ones;
    ones = '1;
    return w & (ones >> (96 - bits));
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_busy7"}, 96'(busy7), 96'd0);
    check({tag, "_done7"}, 96'(done7), 96'd0);
    check({tag, "_val7"}, 96'(val7), 96'd0);
    check({tag, "_v7"}, v7, 96'd0);
    check({tag, "_rd7"}, 96'(rd7), 96'd0);
    check({tag, "_sh7"}, 96'(sh7), 96'd0);
    check({tag, "_din7"}, 96'(din7), 96'd0);
    check({tag, "_busy96"}, 96'(busy96), 96'd0);
    check({tag, "_val96"}, 96'(val96), 96'd0);
    check({tag, "_v96"}, v96, 96'd0);
    check({tag, "_rd96"}, 96'(rd96), 96'd0);
    check({tag, "_sh96"}, 96'(sh96), 96'd0);
  endtask

  // Release reset; the 57-bit copy must finish on its own at edge 59.
  task automatic auto_run(input string tag, input logic [95:0] w);
    int d;
    d = -1;
    word7 = w;
    @(negedge clk);
    rstn = 1'b1;
    for (int t = 1; t <= 70 && d < 0; t++) begin
      @(posedge clk);
      #1;
      if (done7) d = t;
    end
    check({tag, "_done_cyc"}, 96'(d), 96'd59);
    check({tag, "_value"}, v7, ref_value(w, 57));
    check({tag, "_valid"}, 96'(val7), 96'd1);
    check({tag, "_u96_idle"}, 96'(busy96), 96'd0);
    check({tag, "_u96_val"}, 96'(val96), 96'd0);
  endtask

  // Start both copies together and track timing against the rules.
  task automatic readout(input string tag,
                         input logic [95:0] w7,
                         input logic [95:0] w96,
                         input logic [95:0] e7,
                         input logic [95:0] e96,
                         input bit noise);
    int d7, d96, nd7, nd96, b7, b96;
    bit held, was_valid;
    logic [95:0] old96;
    d7 = -1; d96 = -1;
    nd7 = 0; nd96 = 0; b7 = 0; b96 = 0;
    held = 1'b1;
    word7 = w7;
    word96 = w96;
    old96 = v96;
    was_valid = val96;
    st7 = 1'b1;
    st96 = 1'b1;
    @(posedge clk);
    #1;
    st7 = 1'b0;
    st96 = 1'b0;
    for (int t = 0; t < 102; t++) begin
      if (busy7) b7++;
      if (busy96) b96++;
      if (done7) begin nd7++; d7 = t; end
      if (done96) begin nd96++; d96 = t; end
      if (was_valid && d96 < 0 &&
          (val96 !== 1'b1 || v96 !== old96)) held = 1'b0;
      if (noise && t < 56) st7 = 1'($urandom_range(0, 1));
      else st7 = 1'b0;
      if (noise && t < 95) st96 = 1'($urandom_range(0, 1));
      else st96 = 1'b0;
      @(posedge clk);
      #1;
    end
    st7 = 1'b0;
    st96 = 1'b0;
    check({tag, "_done7_t"}, 96'(d7), 96'd58);
    check({tag, "_done96_t"}, 96'(d96), 96'd97);
    check({tag, "_busy7_n"}, 96'(b7), 96'd58);
    check({tag, "_busy96_n"}, 96'(b96), 96'd97);
    check({tag, "_pulses7"}, 96'(nd7), 96'd1);
    check({tag, "_pulses96"}, 96'(nd96), 96'd1);
    check({tag, "_v7"}, v7, e7);
    check({tag, "_v96"}, v96, e96);
    check({tag, "_val7"}, 96'(val7), 96'd1);
    check({tag, "_val96"}, 96'(val96), 96'd1);
    check({tag, "_held96"}, 96'(held), 96'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [95:0] r7, r96;
    tbl[0] = '{96'hA5A5_0000_1234_5678_9ABC_DEF0,
               96'h0000_0000_0034_5678_9ABC_DEF0,
               96'hA5A5_0000_1234_5678_9ABC_DEF0};
    tbl[1] = '{96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               96'h0000_0000_01FF_FFFF_FFFF_FFFF,
               96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    tbl[2] = '{96'h0, 96'h0, 96'h0};
    tbl[3] = '{96'h8000_0000_0000_0000_0000_0001,
               96'h0000_0000_0000_0000_0000_0001,
               96'h8000_0000_0000_0000_0000_0001};
    tbl[4] = '{96'h0000_0000_0100_0000_0000_0000,
               96'h0000_0000_0100_0000_0000_0000,
               96'h0000_0000_0100_0000_0000_0000};
    tbl[5] = '{96'h0000_0000_0200_0000_0000_0000,
               96'h0,
               96'h0000_0000_0200_0000_0000_0000};

    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    check("fam7", 96'(fam7), 96'd7);
    check("fam96", 96'(fam96), 96'd2);

    auto_run("auto", 96'h0000_0000_0010_2030_4050_6070);
    check("auto_spec_value", v7, 96'h0010203040506070);

    for (int i = 0; i < 6; i++) begin
`ifdef DNA_READOUT_MATCH_EN
      exp7_i  = (i % 2 == 1) ? tbl[i].exp57 ^ 96'd1 : tbl[i].exp57;
      exp96_i = (i % 2 == 1) ? tbl[i].exp96 ^ 96'd1 : tbl[i].exp96;
`endif
      readout($sformatf("tbl%0d", i), tbl[i].word, tbl[i].word,
              tbl[i].exp57, tbl[i].exp96, 1'b0);
`ifdef DNA_READOUT_MATCH_EN
      check($sformatf("tbl%0d_mt7", i), 96'(mt7),
            96'(i % 2 == 0));
      check($sformatf("tbl%0d_mt96", i), 96'(mt96),
            96'(i % 2 == 0));
`endif
    end

    for (int i = 0; i < 8; i++) begin
      r7  = {$urandom, $urandom, $urandom};
      r96 = {$urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
`ifdef DNA_READOUT_MATCH_EN
      exp7_i  = ref_value(r7, 57);
      exp96_i = ref_value(r96, 96);
`endif
      readout($sformatf("rnd%0d", i), r7, r96,
              ref_value(r7, 57), ref_value(r96, 96), 1'b1);
`ifdef DNA_READOUT_MATCH_EN
      check($sformatf("rnd%0d_mt96", i), 96'(mt96), 96'd1);
`endif
    end

    // Clear during SHIFT at cnt 20 on the 96-bit copy.
    st96 = 1'b1;
    @(posedge clk);
    #1;
    st96 = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check("clr_pre_shift", 96'(sh96), 96'd1);
    cl96 = 1'b1;
    @(posedge clk);
    #1;
    cl96 = 1'b0;
    check("clr_busy", 96'(busy96), 96'd0);
    check("clr_rd", 96'(rd96), 96'd0);
    check("clr_sh", 96'(sh96), 96'd0);
    check("clr_val", 96'(val96), 96'd0);
    check("clr_v", v96, 96'd0);
`ifdef DNA_READOUT_MATCH_EN
    check("clr_mt", 96'(mt96), 96'd0);
`endif

    // Clear and start together from DONE: clear wins.
    st7 = 1'b1;
    cl7 = 1'b1;
    @(posedge clk);
    #1;
    st7 = 1'b0;
    cl7 = 1'b0;
    check("cw_busy", 96'(busy7), 96'd0);
    check("cw_val", 96'(val7), 96'd0);
    check("cw_v", v7, 96'd0);
    @(posedge clk);
    #1;
    check("cw_busy2", 96'(busy7), 96'd0);

    // Asynchronous reset in the middle of SHIFT.
    st7 = 1'b1;
    st96 = 1'b1;
    @(posedge clk);
    #1;
    st7 = 1'b0;
    st96 = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    reset_checks("arst");
    repeat (2) @(posedge clk);
    #1;
    reset_checks("arst_hold");
    auto_run("rearm", {$urandom, $urandom, $urandom});

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
